dmem_dump: RTL and testbench
============================

Name: dmem_dump

Overview:
Read-side counterpart to the processor's data-memory write path. After a program runs, it takes over the dmem address port and reads a contiguous window of words out of dmem. Each word is presented on a valid/ready output stream for a test harness, UART bridge or scan chain to consume. It sits beside the processor at top level; a mux selects its address onto dmem whenever dmem_req is high.

Parameters:
ADDR_W, 12, dmem word-address width
DATA_W, 32, dmem word width
READ_LAT, 1, clock cycles from driving dmem_address to dmem_q valid at the processor clock edge; legal range 1..4

Ports:
clock  input  1  master clock; all state updates on rising edge
reset  input  1  asynchronous, active-low; 0 = in reset
start  input  1  single-cycle request to begin a dump
base_addr  input  ADDR_W  first word address, sampled on accepted start
word_count  input  ADDR_W+1  number of words to dump (0..4096), sampled on accepted start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when a dump completes, including a zero-length dump
dmem_req  output  1  high while the block owns the dmem address port
dmem_address  output  ADDR_W  word address to dmem
dmem_q  input  DATA_W  read data from dmem
out_valid  output  1  out_data, out_addr and out_last are valid
out_ready  input  1  consumer accepts the word this cycle
out_data  output  DATA_W  captured dmem word
out_addr  output  ADDR_W  address the word was read from
out_last  output  1  marks the final word of the dump

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. busy, done, dmem_req, out_valid and out_last are 0. dmem_address, out_data and out_addr are 0. Internal counters are 0. Reset mid-dump aborts immediately; no done pulse is produced.
- States: IDLE, ISSUE, WAIT, SEND, DONE.
- IDLE: start=1 with word_count!=0 latches addr=base_addr and remain=word_count, then goes to ISSUE. start=1 with word_count==0 goes to DONE without touching dmem. start is ignored in every other state.
- ISSUE (1 cycle): dmem_req=1 and dmem_address=addr. Loads lat_cnt=READ_LAT-1. Goes to WAIT.
- WAIT: dmem_req=1 and dmem_address stays held at addr.
  - When lat_cnt==0: captures out_data<=dmem_q, out_addr<=addr and out_last<=(remain==1), then goes to SEND.
  - Otherwise decrements lat_cnt.
- SEND: out_valid=1, dmem_req=0. out_data, out_addr and out_last stay stable until handshake (out_valid&out_ready).
  - On handshake, if remain==1: go to DONE.
  - On handshake otherwise: addr<=addr+1 (wraps 4095->0 modulo 2^ADDR_W), remain<=remain-1, go to ISSUE.
  - out_valid drops in the cycle after handshake.
- DONE (1 cycle): done=1, busy=0, then goes to IDLE. A start arriving in DONE is ignored.
- busy=1 in ISSUE, WAIT and SEND.
- Throughput: one word per READ_LAT+2 cycles with out_ready held high. There are no back-to-back reads; simplicity is preferred over bandwidth.
- out_ready asserted while out_valid=0 has no effect.
- word_count=4096 dumps the whole memory. Starting at base_addr=4090 wraps: addresses 4090..4095, then 0...
- dmem write enable is never driven by this block. The top-level mux must hold processor wren low while dmem_req=1.

Decomposition:
- Shared package/header dmem_dump_defs:
  - state encoding constants S_IDLE..S_DONE (3-bit)
  - DMEM_ADDR_W=12 and DMEM_DATA_W=32, shared with the processor/dmem wrapper
- No sub-module is needed. A single FSM plus an address counter, remain counter and latency counter stays under 200 lines.
- The top-level dmem address mux is external to this block.

Test Plan:
- Basic dump: preload dmem[10..12]=0xA,0xB,0xC; start, base=10, count=3, out_ready=1 -> three words (10,0xA), (11,0xB), (12,0xC); out_last only on the third; done pulse 1 cycle after the last handshake; busy low after.
- Backpressure: count=2, out_ready=0 for 5 cycles after first out_valid -> out_data/out_addr stable all 5 cycles; no second dmem read issued until the handshake.
- Wrap: base=4094, count=4, dmem[4094]=1, [4095]=2, [0]=3, [1]=4 -> addresses 4094,4095,0,1 with data 1,2,3,4.
- Zero length: start with count=0 -> done=1 exactly one cycle later, busy never high, dmem_req never high.
- Reset abort: assert reset=0 during WAIT of the 2nd word of a 5-word dump -> all outputs 0 asynchronously, no done; after release, a new start with count=1 completes normally.
- Latency: READ_LAT=3, count=2 -> dmem_address held 3 cycles per word; captured data matches dmem; start pulses during busy are ignored.

Source files
------------

// File: rtl/dmem_dump_pkg.sv
// Shared dmem geometry and dump-FSM state encoding.
package dmem_dump_pkg;

  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/dmem_dump.sv
// Reads a contiguous window of dmem words onto a valid/ready stream after a program run.
// Latency: READ_LAT+2 cycles per word (issue, READ_LAT wait cycles, send); no overlapping reads.
// Backpressure: word held stable on out_* until out_ready; next read is not issued before the handshake.
module dmem_dump
  import dmem_dump_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              dmem_req,
  output logic [ADDR_W-1:0] dmem_address,
  input  logic [DATA_W-1:0] dmem_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remain;
  logic [1:0]        lat_cnt;
  logic              last_word;
  logic              hs;

  assign last_word    = (remain == (ADDR_W+1)'(1));
  assign hs           = (state == S_SEND) && out_ready;
  // Address register drives dmem directly; the external mux only looks at it while dmem_req is high.
  assign dmem_address = addr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    dmem_req  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (word_count != '0) ? S_ISSUE : S_DONE;
      end
      S_ISSUE: begin
        busy      = 1'b1;
        dmem_req  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy     = 1'b1;
        dmem_req = 1'b1;
        if (lat_cnt == 2'd0) state_nxt = S_SEND;
      end
      S_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (hs) state_nxt = last_word ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr     <= '0;
      remain   <= '0;
      lat_cnt  <= '0;
      out_data <= '0;
      out_addr <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (word_count != '0)) begin
            addr   <= base_addr;
            remain <= word_count;
          end
        end
        S_ISSUE: lat_cnt <= LAT_INIT;
        S_WAIT: begin
          if (lat_cnt == 2'd0) begin
            out_data <= dmem_q;
            out_addr <= addr;
            out_last <= last_word;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_SEND: begin
          // Address wraps naturally modulo 2^ADDR_W.
          if (hs && !last_word) begin
            addr   <= addr + ADDR_W'(1);
            remain <= remain - (ADDR_W+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dump.sv
// Directed bench for dmem_dump: table-driven dumps on a READ_LAT=1 instance plus hand sequences for
// backpressure, zero length, reset abort and a READ_LAT=3 instance.
module tb_dmem_dump;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;

  logic          start_1, busy_1, done_1, dmem_req_1, out_valid_1, out_ready_1, out_last_1;
  logic [AW-1:0] base_addr_1, dmem_address_1, out_addr_1;
  logic [AW:0]   word_count_1;
  logic [DW-1:0] dmem_q_1, out_data_1;

  logic          start_3, busy_3, done_3, dmem_req_3, out_valid_3, out_ready_3, out_last_3;
  logic [AW-1:0] base_addr_3, dmem_address_3, out_addr_3;
  logic [AW:0]   word_count_3;
  logic [DW-1:0] dmem_q_3, out_data_3;

  logic [DW-1:0] mem [4096];
  logic [DW-1:0] p3_0, p3_1;

  int total  = 0;
  int passed = 0;

  dmem_dump #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .start(start_1), .base_addr(base_addr_1),
    .word_count(word_count_1), .busy(busy_1), .done(done_1), .dmem_req(dmem_req_1),
    .dmem_address(dmem_address_1), .dmem_q(dmem_q_1), .out_valid(out_valid_1),
    .out_ready(out_ready_1), .out_data(out_data_1), .out_addr(out_addr_1), .out_last(out_last_1)
  );

  dmem_dump #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .start(start_3), .base_addr(base_addr_3),
    .word_count(word_count_3), .busy(busy_3), .done(done_3), .dmem_req(dmem_req_3),
    .dmem_address(dmem_address_3), .dmem_q(dmem_q_3), .out_valid(out_valid_3),
    .out_ready(out_ready_3), .out_data(out_data_3), .out_addr(out_addr_3), .out_last(out_last_3)
  );

  always #5 clock = ~clock;

  // Synchronous memory models: 1-stage and 3-stage read pipelines.
  always @(posedge clock) begin
    dmem_q_1 <= mem[dmem_address_1];
    p3_0     <= mem[dmem_address_3];
    p3_1     <= p3_0;
    dmem_q_3 <= p3_1;
  end

  typedef struct {
    logic          first;
    logic [AW-1:0] base;
    logic [AW:0]   count;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_vld1();
    for (int n = 0; n < 50 && !out_valid_1; n++) tick();
    chk("out_valid_seen", {31'd0, out_valid_1}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int reqcnt, addr_bad;
    reset = 1'b0;
    start_1 = 0; base_addr_1 = '0; word_count_1 = '0; out_ready_1 = 1'b1;
    start_3 = 0; base_addr_3 = '0; word_count_3 = '0; out_ready_3 = 1'b1;

    mem[10] = 32'hA;  mem[11] = 32'hB;  mem[12] = 32'hC;
    mem[4094] = 32'd1; mem[4095] = 32'd2; mem[0] = 32'd3; mem[1] = 32'd4;
    mem[100] = 32'hDEAD_BEEF;
    mem[20] = 32'h2020; mem[21] = 32'h2121;
    for (int a = 30; a < 35; a++) mem[a] = 32'h3000 + a;
    mem[40] = 32'h4040;
    mem[50] = 32'h5050; mem[51] = 32'h5151;

    vecs[0] = '{1'b1, 12'd10,   13'd3, 12'd10,   32'hA,         1'b0};
    vecs[1] = '{1'b0, 12'd10,   13'd3, 12'd11,   32'hB,         1'b0};
    vecs[2] = '{1'b0, 12'd10,   13'd3, 12'd12,   32'hC,         1'b1};
    vecs[3] = '{1'b1, 12'd4094, 13'd4, 12'd4094, 32'd1,         1'b0};
    vecs[4] = '{1'b0, 12'd4094, 13'd4, 12'd4095, 32'd2,         1'b0};
    vecs[5] = '{1'b0, 12'd4094, 13'd4, 12'd0,    32'd3,         1'b0};
    vecs[6] = '{1'b0, 12'd4094, 13'd4, 12'd1,    32'd4,         1'b1};
    vecs[7] = '{1'b1, 12'd100,  13'd1, 12'd100,  32'hDEAD_BEEF, 1'b1};

    // Reset state
    #12;
    chk("rst_busy",  {31'd0, busy_1}, 0);
    chk("rst_done",  {31'd0, done_1}, 0);
    chk("rst_req",   {31'd0, dmem_req_1}, 0);
    chk("rst_vld",   {31'd0, out_valid_1}, 0);
    chk("rst_last",  {31'd0, out_last_1}, 0);
    chk("rst_daddr", {20'd0, dmem_address_1}, 0);
    chk("rst_odata", out_data_1, 0);
    chk("rst_oaddr", {20'd0, out_addr_1}, 0);
    reset = 1'b1;
    tick();

    // Table-driven dumps with out_ready held high
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].first) begin
        base_addr_1 = vecs[i].base; word_count_1 = vecs[i].count; start_1 = 1'b1;
        tick();
        start_1 = 1'b0;
        chk("start_busy", {31'd0, busy_1}, 1);
        chk("issue_req",  {31'd0, dmem_req_1}, 1);
        chk("issue_addr", {20'd0, dmem_address_1}, {20'd0, vecs[i].base});
      end
      wait_vld1();
      chk("word_addr", {20'd0, out_addr_1}, {20'd0, vecs[i].addr});
      chk("word_data", out_data_1, vecs[i].data);
      chk("word_last", {31'd0, out_last_1}, {31'd0, vecs[i].last});
      tick();
      if (vecs[i].last) begin
        chk("done_pulse", {31'd0, done_1}, 1);
        chk("done_busy",  {31'd0, busy_1}, 0);
        tick();
        chk("done_clear", {31'd0, done_1}, 0);
        chk("idle_busy",  {31'd0, busy_1}, 0);
      end else begin
        chk("vld_drop", {31'd0, out_valid_1}, 0);
      end
    end

    // Backpressure: word held for 5 cycles, no read issued until handshake
    out_ready_1 = 1'b0;
    base_addr_1 = 12'd20; word_count_1 = 13'd2; start_1 = 1'b1;
    tick();
    start_1 = 1'b0;
    wait_vld1();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_vld",  {31'd0, out_valid_1}, 1);
      chk("bp_data", out_data_1, 32'h2020);
      chk("bp_addr", {20'd0, out_addr_1}, 32'd20);
      chk("bp_req",  {31'd0, dmem_req_1}, 0);
    end
    out_ready_1 = 1'b1;
    tick();
    chk("bp_vld_drop", {31'd0, out_valid_1}, 0);
    chk("bp_req2",     {31'd0, dmem_req_1}, 1);
    chk("bp_daddr2",   {20'd0, dmem_address_1}, 32'd21);
    wait_vld1();
    chk("bp_data2", out_data_1, 32'h2121);
    chk("bp_last2", {31'd0, out_last_1}, 1);
    tick();
    chk("bp_done", {31'd0, done_1}, 1);
    tick();

    // Zero length; a start held into DONE is ignored
    base_addr_1 = 12'd5; word_count_1 = 13'd0; start_1 = 1'b1;
    tick();
    chk("zl_done", {31'd0, done_1}, 1);
    chk("zl_busy", {31'd0, busy_1}, 0);
    chk("zl_req",  {31'd0, dmem_req_1}, 0);
    word_count_1 = 13'd1;
    tick();
    start_1 = 1'b0;
    chk("zl_done_clr", {31'd0, done_1}, 0);
    chk("zl_busy2",    {31'd0, busy_1}, 0);
    chk("zl_req2",     {31'd0, dmem_req_1}, 0);
    tick();
    chk("zl_ignored", {31'd0, busy_1}, 0);

    // Reset abort during WAIT of the 2nd word of a 5-word dump
    base_addr_1 = 12'd30; word_count_1 = 13'd5; start_1 = 1'b1;
    tick();
    start_1 = 1'b0;
    wait_vld1();
    chk("ab_data1", out_data_1, 32'h3000 + 30);
    tick();
    tick();
    chk("ab_in_wait_req",  {31'd0, dmem_req_1}, 1);
    chk("ab_in_wait_addr", {20'd0, dmem_address_1}, 32'd31);
    #2 reset = 1'b0;
    #1;
    chk("ab_busy",  {31'd0, busy_1}, 0);
    chk("ab_req",   {31'd0, dmem_req_1}, 0);
    chk("ab_vld",   {31'd0, out_valid_1}, 0);
    chk("ab_daddr", {20'd0, dmem_address_1}, 0);
    chk("ab_odata", out_data_1, 0);
    chk("ab_oaddr", {20'd0, out_addr_1}, 0);
    chk("ab_last",  {31'd0, out_last_1}, 0);
    tick();
    chk("ab_no_done", {31'd0, done_1}, 0);
    reset = 1'b1;
    tick();
    chk("ab_no_done2", {31'd0, done_1}, 0);
    chk("ab_idle",     {31'd0, busy_1}, 0);
    base_addr_1 = 12'd40; word_count_1 = 13'd1; start_1 = 1'b1;
    tick();
    start_1 = 1'b0;
    wait_vld1();
    chk("ab_re_data", out_data_1, 32'h4040);
    chk("ab_re_last", {31'd0, out_last_1}, 1);
    tick();
    chk("ab_re_done", {31'd0, done_1}, 1);
    tick();

    // READ_LAT=3: address held through ISSUE + 3 WAIT cycles; start during busy ignored
    for (int w = 0; w < 2; w++) begin
      if (w == 0) begin
        base_addr_3 = 12'd50; word_count_3 = 13'd2; start_3 = 1'b1;
        tick();
        start_3 = 1'b0;
      end
      reqcnt = 0; addr_bad = 0;
      for (int n = 0; n < 50 && !out_valid_3; n++) begin
        if (dmem_req_3) begin
          reqcnt++;
          if (dmem_address_3 != AW'(50 + w)) addr_bad++;
        end
        if (n == 1) begin
          base_addr_3 = 12'd999; word_count_3 = 13'd7; start_3 = 1'b1;
        end else begin
          start_3 = 1'b0;
        end
        tick();
      end
      start_3 = 1'b0;
      chk("lat_vld",      {31'd0, out_valid_3}, 1);
      chk("lat_req_cyc",  reqcnt, 4);
      chk("lat_addr_hold", addr_bad, 0);
      chk("lat_oaddr",    {20'd0, out_addr_3}, 50 + w);
      chk("lat_data",     out_data_3, (w == 0) ? 32'h5050 : 32'h5151);
      chk("lat_last",     {31'd0, out_last_3}, w);
      tick();
    end
    chk("lat_done", {31'd0, done_3}, 1);
    tick();
    chk("lat_idle", {31'd0, busy_3}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
